// File: rtl/t5_bus_arb.sv
// Two-master arbiter: fetch port (iwb) and data port (dwb) share one Wishbone-style bus.
// Latency: grant one cycle after request; owner ack/data routed back combinationally.
// Backpressure: the owner holds its stb until ack/err; the loser simply waits in its request.
//
// Ports: sclk/srst (sync, active-low), iwb_* fetch master, dwb_* data master,
//        wb_* shared slave side, igrant/dgrant current owner.
// Optional feature macro: T5_ARB_TIMEOUT_EN enables the TMOW-bit bus-timeout counter
// (TMOW must be >= 2); without it iwb_err/dwb_err are tied low and a hung slave stalls forever.
module t5_bus_arb #(
    parameter int TMOW = 8
) (
    input  logic        sclk,
    input  logic        srst,
    input  logic [29:0] iwb_adr,
    input  logic        iwb_stb,
    output logic [31:0] iwb_dti,
    output logic        iwb_ack,
    output logic        iwb_err,
    input  logic [29:0] dwb_adr,
    input  logic [31:0] dwb_dto,
    input  logic [3:0]  dwb_sel,
    input  logic        dwb_wre,
    input  logic        dwb_stb,
    output logic [31:0] dwb_dti,
    output logic        dwb_ack,
    output logic        dwb_err,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dto,
    output logic [3:0]  wb_sel,
    output logic        wb_wre,
    output logic        wb_stb,
    input  logic [31:0] wb_dti,
    input  logic        wb_ack,
    output logic        igrant,
    output logic        dgrant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } state_t;

    state_t state;
    logic   last;       // last owner that completed: 0 = fetch, 1 = data
    logic   own_stb;
    logic   tmo_hit;

    assign igrant  = (state == IBUS);
    assign dgrant  = (state == DBUS);
    assign own_stb = igrant ? iwb_stb : (dgrant ? dwb_stb : 1'b0);

`ifdef T5_ARB_TIMEOUT_EN
    // cnt counts completed unacked grant cycles, so cnt == 2**TMOW-2 marks
    // the (2**TMOW-1)-th grant cycle, the one in which the timeout fires.
    localparam logic [TMOW-1:0] CNT_LAST = {{(TMOW-1){1'b1}}, 1'b0};
    logic [TMOW-1:0] cnt;
    assign tmo_hit = (igrant | dgrant) & (cnt == CNT_LAST);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge sclk) begin
        if (!srst) begin
            state <= IDLE;
            last  <= 1'b0;
`ifdef T5_ARB_TIMEOUT_EN
            cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef T5_ARB_TIMEOUT_EN
                    cnt <= '0;
`endif
                    // Contention goes to the port that did not finish last.
                    if (dwb_stb && (!iwb_stb || !last))
                        state <= DBUS;
                    else if (iwb_stb)
                        state <= IBUS;
                end
                default: begin
                    if (wb_ack) begin
                        state <= IDLE;
                        last  <= dgrant;
                    end else if (!own_stb) begin
                        // Owner abandoned the cycle: no completion, history untouched.
                        state <= IDLE;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        last  <= dgrant;
                    end
`ifdef T5_ARB_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    // Owner-qualified responses; held quiet while reset is asserted so an
    // interrupted transfer never reports completion.
    assign wb_stb  = srst & own_stb;
    assign iwb_ack = srst & igrant & wb_ack;
    assign dwb_ack = srst & dgrant & wb_ack;
    assign iwb_err = srst & igrant & iwb_stb & tmo_hit & ~wb_ack;
    assign dwb_err = srst & dgrant & dwb_stb & tmo_hit & ~wb_ack;
    assign iwb_dti = wb_dti;
    assign dwb_dti = wb_dti;

    always_comb begin
        wb_adr = dwb_adr;
        wb_dto = dwb_dto;
        wb_sel = 4'h0;
        wb_wre = 1'b0;
        if (igrant) begin
            wb_adr = iwb_adr;
            wb_dto = 32'h0;
            wb_sel = 4'hF;
        end else if (dgrant) begin
            wb_sel = dwb_sel;
            wb_wre = dwb_wre;
        end
    end

endmodule
